// File: rtl/alloc_pkg.sv
// Shared types and helpers for the hop-count wormhole output allocator.
package alloc_pkg;

    localparam int DEF_IN_N      = 5;
    localparam int DEF_HOP_CNT_W = 3;
    localparam int DEF_AGE_W     = 4;

    typedef logic [0:0] state_t;
    localparam state_t IDLE   = 1'b0;
    localparam state_t LOCKED = 1'b1;

    // Index of the first set bit of mask[n-1:0], scanning upward from ptr and wrapping.
    // Walking offsets from high to low lets the smallest offset win; returns 0 when empty.
    function automatic int rr_first_set(input logic [31:0] mask, input int n, input int ptr);
        int idx;
        rr_first_set = 0;
        for (int off = 31; off >= 0; off--) begin
            if (off < n) begin
                idx = (ptr + off) % n;
                if (mask[idx]) rr_first_set = idx;
            end
        end
    endfunction

endpackage

// File: rtl/hop_cnt_max_sel.sv
// Combinational max-hop reduction: flags every masked input whose hop count equals the masked maximum.
module hop_cnt_max_sel
    import alloc_pkg::*;
#(
    parameter int IN_N      = DEF_IN_N,
    parameter int HOP_CNT_W = DEF_HOP_CNT_W
) (
    input  logic [IN_N-1:0]           mask_i,
    input  logic [IN_N*HOP_CNT_W-1:0] hop_cnt_i,
    output logic [IN_N-1:0]           tie_o
);

    logic [HOP_CNT_W-1:0] max_hop;

    // NOTE: blocking assignments here on purpose; the running maximum must be visible
    // to the next loop iteration within the same evaluation.
    always_comb begin
        max_hop = '0;
        for (int k = 0; k < IN_N; k++) begin
            if (mask_i[k] && (hop_cnt_i[k*HOP_CNT_W +: HOP_CNT_W] > max_hop))
                max_hop = hop_cnt_i[k*HOP_CNT_W +: HOP_CNT_W];
        end
        tie_o = '0;
        for (int k = 0; k < IN_N; k++) begin
            tie_o[k] = mask_i[k] && (hop_cnt_i[k*HOP_CNT_W +: HOP_CNT_W] == max_hop);
        end
    end

endmodule

// File: rtl/hop_cnt_wh_allocator.sv
// Wormhole output allocator: highest hop count wins, round-robin on ties, grant held head to tail.
// Define HOP_CNT_ALLOC_AGING_EN to add per-input starvation counters that override hop priority.
module hop_cnt_wh_allocator
    import alloc_pkg::*;
#(
    parameter int IN_N      = DEF_IN_N,
    parameter int HOP_CNT_W = DEF_HOP_CNT_W,
    parameter int AGE_W     = DEF_AGE_W
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [IN_N-1:0]           req_i,
    input  logic [IN_N-1:0]           head_i,
    input  logic [IN_N-1:0]           tail_i,
    input  logic [IN_N*HOP_CNT_W-1:0] hop_cnt_i,
    input  logic                      out_rdy_i,
    output logic [IN_N-1:0]           in_rdy_o,
    output logic [IN_N-1:0]           grant_o,
    output logic [$clog2(IN_N)-1:0]   grant_idx_o,
    output logic                      busy_o,
    output logic                      xfer_o
);

    localparam int IDX_W = $clog2(IN_N);

    state_t                 state_q, state_d;
    logic [IN_N-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic [IN_N-1:0]        cand;
    logic [IN_N-1:0]        hop_tie;
    logic [IN_N-1:0]        tie;
    logic [IDX_W-1:0]       winner;
    logic                   tail_xfer;

    assign cand = req_i & head_i;

    hop_cnt_max_sel #(
        .IN_N      (IN_N),
        .HOP_CNT_W (HOP_CNT_W)
    ) u_max_sel (
        .mask_i    (cand),
        .hop_cnt_i (hop_cnt_i),
        .tie_o     (hop_tie)
    );

`ifdef HOP_CNT_ALLOC_AGING_EN
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [AGE_W-1:0] age_q [IN_N];
    logic [IN_N-1:0]  aged;

    always_comb begin
        for (int k = 0; k < IN_N; k++) aged[k] = cand[k] && (age_q[k] == AGE_MAX);
    end

    // A starved candidate outranks hop count; round-robin still picks among the starved ones.
    assign tie = (|aged) ? aged : hop_tie;

    // NOTE: the age array is a handful of flops, not a RAM, so it takes the async reset
    // like any other state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < IN_N; k++) age_q[k] <= '0;
        end else if (state_q == IDLE && (|cand)) begin
            for (int k = 0; k < IN_N; k++) begin
                if (winner == IDX_W'(k))
                    age_q[k] <= '0;
                else if (cand[k] && (age_q[k] != AGE_MAX))
                    age_q[k] <= age_q[k] + AGE_W'(1);
            end
        end
    end
`else
    assign tie = hop_tie;
`endif

    assign winner = IDX_W'(rr_first_set(32'(tie), IN_N, int'(rr_ptr_q)));

    assign in_rdy_o    = grant_q & {IN_N{out_rdy_i}};
    assign xfer_o      = out_rdy_i & (|(grant_q & req_i));
    assign tail_xfer   = xfer_o & (|(grant_q & tail_i));
    assign grant_o     = grant_q;
    assign grant_idx_o = grant_idx_q;
    assign busy_o      = (state_q == LOCKED);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d     = LOCKED;
                    grant_d     = IN_N'(1) << winner;
                    grant_idx_d = winner;
                end
            end
            default: begin
                // Lock released only by a transferred tail; a dropped req keeps the wormhole.
                if (tail_xfer) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (grant_idx_q == IDX_W'(IN_N - 1)) ? '0 : grant_idx_q + IDX_W'(1);
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule

// File: doc/hop_cnt_wh_allocator.md
Name: hop_cnt_wh_allocator

Overview:
- Sequential output-port allocator for one router output in the mesh switch.
- Arbitrates head flits from IN_N input buffers:
  - highest hop count wins;
  - ties are broken round-robin.
- Holds the grant for the whole wormhole packet, head through tail.
- Drives the output crossbar select and per-input ready handshake.

Parameters:
- IN_N, 5, number of requesting input ports (mesh: N/E/S/W/Local).
- HOP_CNT_W, 3, width of each hop-count field.
- AGE_W, 4, width of per-input starvation counter (used only with the optional feature).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  IN_N  per-input flit valid.
- head_i  in  IN_N  per-input flit is a head flit (qualified by req_i).
- tail_i  in  IN_N  per-input flit is a tail flit; head+tail means a single-flit packet.
- hop_cnt_i  in  IN_N*HOP_CNT_W  packed hop counts; input k occupies bits [k*HOP_CNT_W +: HOP_CNT_W].
- out_rdy_i  in  1  downstream (next router or local sink) can accept a flit.
- in_rdy_o  out  IN_N  per-input pop/ready; at most one bit set.
- grant_o  out  IN_N  one-hot current owner of the output.
- grant_idx_o  out  $clog2(IN_N)  binary index of the owner; drives the crossbar select.
- busy_o  out  1  output is locked to a packet.
- xfer_o  out  1  flit transferred this cycle.

Behaviour:
- Reset (rst_ni low, async): state IDLE; grant_o=0; grant_idx_o=0; busy_o=0; rr_ptr=0; all age counters=0. Combinational outputs in_rdy_o=0 and xfer_o=0 follow from grant_o=0.
- States are IDLE and LOCKED.
- IDLE:
  - cand = req_i & head_i. Non-head flits with req_i high are ignored in IDLE.
  - If cand==0, stay in IDLE.
  - Otherwise compute max hop count over cand; tie = cand bits whose hop count equals the max.
  - Winner = first set bit of tie scanning circularly from rr_ptr upward (wraps IN_N-1 to 0).
  - At the next edge: grant_o=onehot(winner), grant_idx_o=winner, busy_o=1, state=LOCKED.
  - Latency: request at cycle N gives grant at N+1 and first possible transfer at N+1.
- LOCKED, owner g:
  - in_rdy_o[g] = out_rdy_i; all other in_rdy_o bits are 0 (combinational).
  - xfer_o = req_i[g] & out_rdy_i.
  - If xfer_o & tail_i[g]: at the next edge state=IDLE, grant_o=0, busy_o=0, rr_ptr=(g+1) mod IN_N.
  - Otherwise the grant holds. It also holds if req_i[g] drops mid-packet (wormhole lock), and regardless of other inputs' requests.
- After a tail there is exactly one IDLE bubble cycle before the next grant. A new head in the tail cycle is arbitrated in the following cycle.
- Single-flit packet: granted at N+1; with out_rdy_i=1 it transfers at N+1 and returns to IDLE at N+2.
- rr_ptr changes only on tail transfer; it is never updated in IDLE.
- hop_cnt_i compare is unsigned; max value 2^HOP_CNT_W-1 has no saturation special case.
- Async reset mid-packet returns to IDLE immediately; the partial packet is abandoned (upstream flushed by the same reset).

Optional Feature:
- Macro HOP_CNT_ALLOC_AGING_EN.
- Defined:
  - Each input has a saturating AGE_W-bit counter, incremented on every IDLE arbitration edge where its cand bit is set and it loses.
  - The counter clears when that input is granted.
  - If any cand input has age == 2^AGE_W-1, cand is restricted to those aged inputs and hop count is ignored. Round-robin from rr_ptr still applies.
- Not defined:
  - No counters are instantiated.
  - Pure hop-count plus round-robin; a low-hop input can starve.

Decomposition:
- Shared package alloc_pkg:
  - state typedef (IDLE=1'b0, LOCKED=1'b1);
  - function for circular first-set index from a pointer;
  - default widths.
- One sub-module hop_cnt_max_sel:
  - combinational, IN_N-generic max reduction over masked hop counts;
  - returns the tie mask.
- Round-robin pick, FSM, and aging counters stay in the top.

Test Plan (IN_N=5, HOP_CNT_W=3):
- Reset check: hold rst_ni=0 with random inputs -> grant_o=0, busy_o=0, in_rdy_o=0; release -> still IDLE until a head arrives.
- Hop priority: heads on inputs 0,2,4 with hops 1,6,3 -> cycle+1 grant_o=5'b00100, grant_idx_o=2; 3-flit packet with out_rdy_i=1 -> xfer_o three cycles, IDLE on the fourth.
- Tie round-robin: inputs 1 and 3 both hop 5, rr_ptr=0 -> grant 1; after its tail, rr_ptr=2; repeat tie -> grant 3.
- Backpressure and lock: owner 4, out_rdy_i=0 for 3 cycles while input 0 sends hop 7 head -> grant stays 4, xfer_o=0, in_rdy_o=0; release -> packet completes, then input 0 granted after one bubble.
- Single-flit plus mid-reset: head&tail on input 3 -> grant, transfer, IDLE in consecutive cycles; second packet on 1, assert rst_ni=0 mid-body -> immediate IDLE, grant_o=0.
- Aging (macro on, AGE_W=2): input 0 hop 0 competes with repeated hop-7 packets on input 1 -> after 3 losses input 0 wins the next arbitration; its counter clears.
